decode_hazard_ctrl: RTL and testbench

// Pipeline interlock controller for the decode stage. Tracks in-flight register writes
// (scoreboard), detects load-use and multi-cycle MUL hazards that bypasses cannot cover,
// and drives stall_decode / flush_decode into decode_top. Sits between fetch/decode and ALU/cache/WB.

---
 rtl/decode_hazard_ctrl_pkg.sv | 51 +++++
 rtl/decode_hazard_ctrl_if.sv | 40 ++++
 rtl/decode_scoreboard.sv | 58 +++++
 rtl/decode_hazard_ctrl.sv | 116 +++++++++++
 tb/tb_decode_hazard_ctrl.sv | 397 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_hazard_ctrl_pkg.sv
// Shared definitions for the decode-stage interlock controller: opcode
// constants, instruction-class helpers, hazard cause encoding and the
// register macros used by the controller and its scoreboard.

`ifndef DECODE_HAZARD_CTRL_MACROS
`define DECODE_HAZARD_CTRL_MACROS
`define RST_FF(clk_s, rst_s, rst_val, d_s, q_s) \
   always_ff @(posedge clk_s) begin \
      if (rst_s) q_s <= (rst_val); \
      else q_s <= (d_s); \
   end
`define RST_EN_FF(clk_s, rst_s, en_s, rst_val, d_s, q_s) \
   always_ff @(posedge clk_s) begin \
      if (rst_s) q_s <= (rst_val); \
      else if (en_s) q_s <= (d_s); \
   end
`endif

package decode_hazard_ctrl_pkg;

   localparam int REG_IDX_W = 5;
   localparam int OPCODE_W  = 7;

   localparam logic [OPCODE_W-1:0] OP_LDB = 7'h20;
   localparam logic [OPCODE_W-1:0] OP_LDW = 7'h21;
   localparam logic [OPCODE_W-1:0] OP_STB = 7'h22;
   localparam logic [OPCODE_W-1:0] OP_STW = 7'h23;
   localparam logic [OPCODE_W-1:0] OP_MUL = 7'h30;

   // Reason decode is being held, highest priority first.
   typedef enum logic [2:0] {
      CAUSE_NONE     = 3'd0,
      CAUSE_CACHE    = 3'd1,
      CAUSE_LOAD_USE = 3'd2,
      CAUSE_MUL      = 3'd3,
      CAUSE_SB_FULL  = 3'd4
   } hazard_cause_t;

   function automatic logic is_load_instr(input logic [OPCODE_W-1:0] op);
      return (op == OP_LDB) || (op == OP_LDW);
   endfunction

   function automatic logic is_store_instr(input logic [OPCODE_W-1:0] op);
      return (op == OP_STB) || (op == OP_STW);
   endfunction

   function automatic logic is_mul_instr(input logic [OPCODE_W-1:0] op);
      return op == OP_MUL;
   endfunction

endpackage

// File: rtl/decode_hazard_ctrl_if.sv
// Bundle of decode-side, writeback and pipeline-control signals seen by the
// interlock controller. master = decode/pipeline side, slave = controller.

interface decode_hazard_ctrl_if;
   import decode_hazard_ctrl_pkg::*;

   logic                  dec_valid;
   logic [OPCODE_W-1:0]   dec_opcode;
   logic [REG_IDX_W-1:0]  dec_rd;
   logic [REG_IDX_W-1:0]  dec_ra;
   logic [REG_IDX_W-1:0]  dec_rb;
   logic                  dec_uses_ra;
   logic                  dec_uses_rb;
   logic                  dec_writes_rd;
   logic                  wb_en;
   logic [REG_IDX_W-1:0]  wb_dest;
   logic                  cache_stall;
   logic                  branch_taken;
   logic                  xcpt_flush;
   logic                  stall_decode;
   logic                  flush_decode;
   logic                  issue;
   logic [31:0]           stall_cycles;
   hazard_cause_t         hazard_cause;

   modport master (
      output dec_valid, dec_opcode, dec_rd, dec_ra, dec_rb,
             dec_uses_ra, dec_uses_rb, dec_writes_rd,
             wb_en, wb_dest, cache_stall, branch_taken, xcpt_flush,
      input  stall_decode, flush_decode, issue, stall_cycles, hazard_cause
   );

   modport slave (
      input  dec_valid, dec_opcode, dec_rd, dec_ra, dec_rb,
             dec_uses_ra, dec_uses_rb, dec_writes_rd,
             wb_en, wb_dest, cache_stall, branch_taken, xcpt_flush,
      output stall_decode, flush_decode, issue, stall_cycles, hazard_cause
   );

endinterface

// File: rtl/decode_scoreboard.sv
// Per-register count of in-flight writes. Increments when a writing
// instruction issues, decrements on register-file writeback, clears when the
// pipe is squashed. Register 0 is hardwired to zero and never tracked.

module decode_scoreboard #(
   parameter int  NUM_REGS   = 32,
   parameter int  PEND_WIDTH = 2,
   localparam int IDX_W      = $clog2(NUM_REGS)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc_en,
   input  logic [IDX_W-1:0] inc_idx,
   input  logic             dec_en,
   input  logic [IDX_W-1:0] dec_idx,
   input  logic             clear,
   input  logic [IDX_W-1:0] query_idx,
   output logic             query_full
);

   localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

   logic [PEND_WIDTH-1:0] pend [NUM_REGS];

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
         assign pend[gi] = '0;
      end else begin : g_track
         logic [PEND_WIDTH-1:0] pend_reg;
         logic [PEND_WIDTH-1:0] pend_next;
         logic                  hit_inc;
         logic                  hit_dec;

         assign hit_inc = inc_en && (inc_idx == IDX_W'(gi));
         // A writeback against an empty counter is stale and is dropped.
         assign hit_dec = dec_en && (dec_idx == IDX_W'(gi)) && (pend_reg != '0);

         // Issue and writeback on the same register in one cycle cancel out.
         always_comb begin
            pend_next = pend_reg;
            if (clear)
               pend_next = '0;
            else if (hit_inc && !hit_dec)
               pend_next = pend_reg + 1'b1;
            else if (hit_dec && !hit_inc)
               pend_next = pend_reg - 1'b1;
         end

         // Pending-write counter for this register.
         `RST_FF(clock, reset, '0, pend_next, pend_reg)

         assign pend[gi] = pend_reg;
      end
   end

   assign query_full = (pend[query_idx] == PEND_MAX);

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage interlock controller. Holds decode for cache misses,
// load-use hazards, multi-cycle MUL occupancy and a saturated scoreboard;
// squashes decode on taken branches and exceptions.

module decode_hazard_ctrl
   import decode_hazard_ctrl_pkg::*;
#(
   parameter int NUM_REGS    = 32,
   parameter int MUL_LATENCY = 5,
   parameter int PEND_WIDTH  = 2
) (
   input logic                 clock,
   input logic                 reset,
   decode_hazard_ctrl_if.slave bus
);

   localparam int MUL_CNT_W = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;
   localparam logic [MUL_CNT_W-1:0] MUL_HOLD = MUL_CNT_W'(MUL_LATENCY - 1);

   logic                  alu_ld_valid_reg;
   logic                  alu_ld_valid_next;
   logic [REG_IDX_W-1:0]  alu_ld_rd_reg;
   logic [MUL_CNT_W-1:0]  mul_cnt_reg;
   logic [MUL_CNT_W-1:0]  mul_cnt_next;
   logic [31:0]           stall_cycles_reg;
   logic [31:0]           stall_cycles_next;

   logic          flush;
   logic          load_use;
   logic          mul_busy;
   logic          sb_query_full;
   logic          sb_full;
   logic          stall;
   logic          issue_now;
   logic          load_capture;
   logic          stall_count_en;
   hazard_cause_t cause;

   // Hazard detection; a flush overrides every stall source.
   always_comb begin
      flush    = bus.branch_taken | bus.xcpt_flush;
      load_use = alu_ld_valid_reg &
                 ((bus.dec_uses_ra & (bus.dec_ra == alu_ld_rd_reg)) |
                  (bus.dec_uses_rb & (bus.dec_rb == alu_ld_rd_reg)));
      mul_busy = (mul_cnt_reg != '0);
      sb_full  = bus.dec_writes_rd & sb_query_full;
      stall    = !flush & bus.dec_valid &
                 (bus.cache_stall | load_use | mul_busy | sb_full);
      issue_now = bus.dec_valid & !stall & !flush;
      if (!stall)
         cause = CAUSE_NONE;
      else if (bus.cache_stall)
         cause = CAUSE_CACHE;
      else if (load_use)
         cause = CAUSE_LOAD_USE;
      else if (mul_busy)
         cause = CAUSE_MUL;
      else
         cause = CAUSE_SB_FULL;
   end

   // Load tracker and MUL countdown; an exception drains both.
   always_comb begin
      alu_ld_valid_next = alu_ld_valid_reg;
      mul_cnt_next      = mul_cnt_reg;
      load_capture      = issue_now & is_load_instr(bus.dec_opcode);
      if (bus.xcpt_flush) begin
         alu_ld_valid_next = 1'b0;
         mul_cnt_next      = '0;
      end else begin
         // A cache miss freezes the ALU stage, so the load stays in front of decode.
         if (!bus.cache_stall)
            alu_ld_valid_next = load_capture;
         if (issue_now & is_mul_instr(bus.dec_opcode))
            mul_cnt_next = MUL_HOLD;
         else if (mul_busy)
            mul_cnt_next = mul_cnt_reg - 1'b1;
      end
      stall_count_en    = stall & (stall_cycles_reg != 32'hFFFF_FFFF);
      stall_cycles_next = stall_cycles_reg + 32'd1;
   end

   // Valid flag of the load currently in the ALU stage.
   `RST_FF(clock, reset, 1'b0, alu_ld_valid_next, alu_ld_valid_reg)

   // Destination of the most recently issued load.
   `RST_EN_FF(clock, reset, load_capture, '0, bus.dec_rd, alu_ld_rd_reg)

   // Remaining cycles the multiplier is occupied.
   `RST_FF(clock, reset, '0, mul_cnt_next, mul_cnt_reg)

   // Saturating count of cycles decode was held.
   `RST_EN_FF(clock, reset, stall_count_en, '0, stall_cycles_next, stall_cycles_reg)

   decode_scoreboard #(
      .NUM_REGS   (NUM_REGS),
      .PEND_WIDTH (PEND_WIDTH)
   ) u_scoreboard (
      .clock      (clock),
      .reset      (reset),
      .inc_en     (issue_now & bus.dec_writes_rd),
      .inc_idx    (bus.dec_rd),
      .dec_en     (bus.wb_en),
      .dec_idx    (bus.wb_dest),
      .clear      (bus.xcpt_flush),
      .query_idx  (bus.dec_rd),
      .query_full (sb_query_full)
   );

   assign bus.stall_decode = stall;
   assign bus.flush_decode = flush;
   assign bus.issue        = issue_now;
   assign bus.stall_cycles = stall_cycles_reg;
   assign bus.hazard_cause = cause;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Directed bench for decode_hazard_ctrl. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge. obs = {stall, flush, issue}.

module tb_decode_hazard_ctrl;
   import decode_hazard_ctrl_pkg::*;

   localparam logic [6:0] OP_ADD = 7'h01;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   int         vectors = 0;
   int         miscompares = 0;
   logic [2:0] obs;

   decode_hazard_ctrl_if bus();

   decode_hazard_ctrl #(
      .NUM_REGS    (32),
      .MUL_LATENCY (5),
      .PEND_WIDTH  (2)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] ra, input logic [4:0] rb,
                        input logic ua, input logic ub, input logic wr);
      bus.dec_valid = v;  bus.dec_opcode = op; bus.dec_rd = rd;
      bus.dec_ra = ra;    bus.dec_rb = rb;
      bus.dec_uses_ra = ua; bus.dec_uses_rb = ub; bus.dec_writes_rd = wr;
   endtask

   task automatic side(input logic wb, input logic [4:0] wd, input logic cs,
                       input logic bt, input logic xf);
      bus.wb_en = wb; bus.wb_dest = wd; bus.cache_stall = cs;
      bus.branch_taken = bt; bus.xcpt_flush = xf;
   endtask

   task automatic idle();
      drive(1'b0, 7'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      side(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Sample outputs for the current input vector and log the transaction.
   task automatic look();
      @(negedge clock);
      obs = {bus.stall_decode, bus.flush_decode, bus.issue};
      vectors++;
      $display("txn t=%0t v=%b op=%h rd=%0d ra=%0d rb=%0d wb=%b/%0d cs=%b bt=%b xf=%b -> sfi=%b cnt=%0d",
               $time, bus.dec_valid, bus.dec_opcode, bus.dec_rd, bus.dec_ra, bus.dec_rb,
               bus.wb_en, bus.wb_dest, bus.cache_stall, bus.branch_taken, bus.xcpt_flush,
               obs, bus.stall_cycles);
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      // A stalling instruction during reset must not be counted.
      drive(1'b1, OP_MUL, 5'd2, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1);
      side(1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      idle();
      look();
      if (obs !== 3'b000) begin miscompares++; $display("FAIL reset_outputs: sfi=%b expected 000", obs); end
      vectors++;
      if (bus.stall_cycles !== 32'd0) begin miscompares++; $display("FAIL reset_stall_cycles: got %0d expected 0", bus.stall_cycles); end
      vectors++;
      if (bus.hazard_cause !== CAUSE_NONE) begin miscompares++; $display("FAIL reset_cause: got %0d expected 0", bus.hazard_cause); end
      tick();
      drive(1'b1, OP_ADD, 5'd4, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1);
      look();
      if (obs !== 3'b001) begin miscompares++; $display("FAIL reset_first_issue: sfi=%b expected 001", obs); end
      tick();
   endtask

   task automatic test_load_use();
      do_reset();
      drive(1'b1, OP_LDW, 5'd3, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1);
      look();
      if (obs !== 3'b001) begin miscompares++; $display("FAIL lu_load_issue: sfi=%b expected 001", obs); end
      tick();
      drive(1'b1, OP_ADD, 5'd4, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1);
      look();
      if (obs !== 3'b100) begin miscompares++; $display("FAIL lu_bubble: sfi=%b expected 100", obs); end
      vectors++;
      if (bus.hazard_cause !== CAUSE_LOAD_USE) begin miscompares++; $display("FAIL lu_cause: got %0d expected %0d", bus.hazard_cause, CAUSE_LOAD_USE); end
      tick();
      look();
      if (obs !== 3'b001) begin miscompares++; $display("FAIL lu_issue_after: sfi=%b expected 001", obs); end
      tick();
      drive(1'b1, OP_LDB, 5'd6, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1);
      look();
      if (obs !== 3'b001) begin miscompares++; $display("FAIL lu_ldb_issue: sfi=%b expected 001", obs); end
      tick();
      drive(1'b1, OP_ADD, 5'd8, 5'd9, 5'd6, 1'b1, 1'b1, 1'b1);
      look();
      if (obs !== 3'b100) begin miscompares++; $display("FAIL lu_rb_bubble: sfi=%b expected 100", obs); end
      tick();
      look();
      if (obs !== 3'b001) begin miscompares++; $display("FAIL lu_rb_issue: sfi=%b expected 001", obs); end
      tick();
      drive(1'b1, OP_LDW, 5'd10, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1);
      look();
      if (obs !== 3'b001) begin miscompares++; $display("FAIL lu_ldw2_issue: sfi=%b expected 001", obs); end
      tick();
      drive(1'b1, OP_ADD, 5'd11, 5'd10, 5'd10, 1'b0, 1'b0, 1'b1);
      look();
      if (obs !== 3'b001) begin miscompares++; $display("FAIL lu_unused_src: sfi=%b expected 001", obs); end
      tick();
      idle();
      look();
      vectors++;
      if (bus.stall_cycles !== 32'd2) begin miscompares++; $display("FAIL lu_stall_cycles: got %0d expected 2", bus.stall_cycles); end
      tick();
   endtask

   task automatic test_mul();
      do_reset();
      drive(1'b1, OP_MUL, 5'd2, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1);
      look();
      if (obs !== 3'b001) begin miscompares++; $display("FAIL mul_issue: sfi=%b expected 001", obs); end
      tick();
      drive(1'b1, OP_ADD, 5'd4, 5'd5, 5'd6, 1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 4; k++) begin
         look();
         if (obs !== 3'b100) begin miscompares++; $display("FAIL mul_hold[%0d]: sfi=%b expected 100", k, obs); end
         tick();
      end
      look();
      if (obs !== 3'b001) begin miscompares++; $display("FAIL mul_issue_5th: sfi=%b expected 001", obs); end
      tick();
      drive(1'b1, OP_MUL, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1);
      look();
      if (obs !== 3'b001) begin miscompares++; $display("FAIL mul2_issue: sfi=%b expected 001", obs); end
      tick();
      idle();
      look();
      if (obs !== 3'b000) begin miscompares++; $display("FAIL mul_idle_no_stall: sfi=%b expected 000", obs); end
      tick();
      drive(1'b1, OP_ADD, 5'd4, 5'd5, 5'd6, 1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
         look();
         if (obs !== 3'b100) begin miscompares++; $display("FAIL mul2_hold[%0d]: sfi=%b expected 100", k, obs); end
         tick();
      end
      look();
      if (obs !== 3'b001) begin miscompares++; $display("FAIL mul2_issue_after: sfi=%b expected 001", obs); end
      tick();
      idle();
      look();
      vectors++;
      if (bus.stall_cycles !== 32'd7) begin miscompares++; $display("FAIL mul_stall_cycles: got %0d expected 7", bus.stall_cycles); end
      tick();
   endtask

   task automatic test_sb_full();
      do_reset();
      drive(1'b1, OP_ADD, 5'd7, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
         look();
         if (obs !== 3'b001) begin miscompares++; $display("FAIL sbf_fill[%0d]: sfi=%b expected 001", k, obs); end
         tick();
      end
      look();
      if (obs !== 3'b100) begin miscompares++; $display("FAIL sbf_fourth_stalls: sfi=%b expected 100", obs); end
      vectors++;
      if (bus.hazard_cause !== CAUSE_SB_FULL) begin miscompares++; $display("FAIL sbf_cause: got %0d expected %0d", bus.hazard_cause, CAUSE_SB_FULL); end
      tick();
      side(1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
      look();
      if (obs !== 3'b100) begin miscompares++; $display("FAIL sbf_stall_during_wb: sfi=%b expected 100", obs); end
      tick();
      side(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      look();
      if (obs !== 3'b001) begin miscompares++; $display("FAIL sbf_issue_after_wb: sfi=%b expected 001", obs); end
      tick();
      drive(1'b1, OP_ADD, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 4; k++) begin
         look();
         if (obs !== 3'b001) begin miscompares++; $display("FAIL sbf_r0_untracked[%0d]: sfi=%b expected 001", k, obs); end
         tick();
      end
      idle();
      look();
      vectors++;
      if (bus.stall_cycles !== 32'd2) begin miscompares++; $display("FAIL sbf_stall_cycles: got %0d expected 2", bus.stall_cycles); end
      tick();
   endtask

   task automatic test_same_cycle();
      do_reset();
      drive(1'b1, OP_ADD, 5'd9, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1);
      look();
      if (obs !== 3'b001) begin miscompares++; $display("FAIL sc_first: sfi=%b expected 001", obs); end
      tick();
      side(1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
      look();
      if (obs !== 3'b001) begin miscompares++; $display("FAIL sc_issue_and_wb: sfi=%b expected 001", obs); end
      tick();
      side(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         look();
         if (obs !== 3'b001) begin miscompares++; $display("FAIL sc_refill[%0d]: sfi=%b expected 001", k, obs); end
         tick();
      end
      look();
      if (obs !== 3'b100) begin miscompares++; $display("FAIL sc_pend_held: sfi=%b expected 100", obs); end
      tick();
      idle();
      side(1'b1, 5'd10, 1'b0, 1'b0, 1'b0);
      look();
      if (obs !== 3'b000) begin miscompares++; $display("FAIL sc_wb_at_zero: sfi=%b expected 000", obs); end
      tick();
      side(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, OP_ADD, 5'd10, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
         look();
         if (obs !== 3'b001) begin miscompares++; $display("FAIL sc_no_wrap[%0d]: sfi=%b expected 001", k, obs); end
         tick();
      end
      look();
      if (obs !== 3'b100) begin miscompares++; $display("FAIL sc_r10_full: sfi=%b expected 100", obs); end
      tick();
      idle();
      look();
      vectors++;
      if (bus.stall_cycles !== 32'd2) begin miscompares++; $display("FAIL sc_stall_cycles: got %0d expected 2", bus.stall_cycles); end
      tick();
   endtask

   task automatic test_xcpt_flush();
      do_reset();
      drive(1'b1, OP_ADD, 5'd11, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
         look();
         if (obs !== 3'b001) begin miscompares++; $display("FAIL xf_fill[%0d]: sfi=%b expected 001", k, obs); end
         tick();
      end
      drive(1'b1, OP_MUL, 5'd13, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1);
      look();
      if (obs !== 3'b001) begin miscompares++; $display("FAIL xf_mul_issue: sfi=%b expected 001", obs); end
      tick();
      drive(1'b1, OP_ADD, 5'd14, 5'd5, 5'd6, 1'b1, 1'b1, 1'b1);
      side(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      look();
      if (obs !== 3'b010) begin miscompares++; $display("FAIL xf_flush_over_mul: sfi=%b expected 010", obs); end
      tick();
      side(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, OP_ADD, 5'd11, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1);
      look();
      if (obs !== 3'b001) begin miscompares++; $display("FAIL xf_drained: sfi=%b expected 001", obs); end
      tick();
      drive(1'b1, OP_LDW, 5'd12, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1);
      look();
      if (obs !== 3'b001) begin miscompares++; $display("FAIL xf_ldw_issue: sfi=%b expected 001", obs); end
      tick();
      drive(1'b1, OP_ADD, 5'd15, 5'd12, 5'd1, 1'b1, 1'b1, 1'b1);
      side(1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
      look();
      if (obs !== 3'b010) begin miscompares++; $display("FAIL xf_over_cache_stall: sfi=%b expected 010", obs); end
      tick();
      side(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      look();
      if (obs !== 3'b001) begin miscompares++; $display("FAIL xf_ld_cleared: sfi=%b expected 001", obs); end
      tick();
      idle();
      look();
      vectors++;
      if (bus.stall_cycles !== 32'd0) begin miscompares++; $display("FAIL xf_stall_cycles: got %0d expected 0", bus.stall_cycles); end
      tick();
   endtask

   task automatic test_branch();
      do_reset();
      drive(1'b1, OP_ADD, 5'd15, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1);
      side(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      look();
      if (obs !== 3'b010) begin miscompares++; $display("FAIL br_squash: sfi=%b expected 010", obs); end
      tick();
      side(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         look();
         if (obs !== 3'b001) begin miscompares++; $display("FAIL br_fill[%0d]: sfi=%b expected 001", k, obs); end
         tick();
      end
      look();
      if (obs !== 3'b100) begin miscompares++; $display("FAIL br_full: sfi=%b expected 100", obs); end
      tick();
      side(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      look();
      if (obs !== 3'b010) begin miscompares++; $display("FAIL br_flush_over_sbfull: sfi=%b expected 010", obs); end
      tick();
      side(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      look();
      if (obs !== 3'b100) begin miscompares++; $display("FAIL br_no_pend_change: sfi=%b expected 100", obs); end
      tick();
      idle();
      side(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      look();
      if (obs !== 3'b010) begin miscompares++; $display("FAIL br_flush_no_valid: sfi=%b expected 010", obs); end
      tick();
      idle();
      look();
      vectors++;
      if (bus.stall_cycles !== 32'd2) begin miscompares++; $display("FAIL br_stall_cycles: got %0d expected 2", bus.stall_cycles); end
      tick();
   endtask

   task automatic test_cache_stall();
      do_reset();
      drive(1'b1, OP_LDW, 5'd3, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1);
      look();
      if (obs !== 3'b001) begin miscompares++; $display("FAIL cs_load_issue: sfi=%b expected 001", obs); end
      tick();
      drive(1'b1, OP_ADD, 5'd4, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1);
      side(1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         look();
         if (obs !== 3'b100) begin miscompares++; $display("FAIL cs_hold[%0d]: sfi=%b expected 100", k, obs); end
         vectors++;
         if (bus.hazard_cause !== CAUSE_CACHE) begin miscompares++; $display("FAIL cs_cause[%0d]: got %0d expected %0d", k, bus.hazard_cause, CAUSE_CACHE); end
         tick();
      end
      side(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      look();
      if (obs !== 3'b100) begin miscompares++; $display("FAIL cs_release_bubble: sfi=%b expected 100", obs); end
      vectors++;
      if (bus.hazard_cause !== CAUSE_LOAD_USE) begin miscompares++; $display("FAIL cs_release_cause: got %0d expected %0d", bus.hazard_cause, CAUSE_LOAD_USE); end
      tick();
      look();
      if (obs !== 3'b001) begin miscompares++; $display("FAIL cs_issue_after: sfi=%b expected 001", obs); end
      tick();
      idle();
      side(1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
      look();
      if (obs !== 3'b000) begin miscompares++; $display("FAIL cs_no_valid: sfi=%b expected 000", obs); end
      tick();
      idle();
      look();
      vectors++;
      if (bus.stall_cycles !== 32'd3) begin miscompares++; $display("FAIL cs_stall_cycles: got %0d expected 3", bus.stall_cycles); end
      tick();
   endtask

   task automatic test_reset_mid_mul();
      do_reset();
      drive(1'b1, OP_MUL, 5'd2, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1);
      look();
      if (obs !== 3'b001) begin miscompares++; $display("FAIL rmm_mul_issue: sfi=%b expected 001", obs); end
      tick();
      drive(1'b1, OP_ADD, 5'd4, 5'd5, 5'd6, 1'b1, 1'b1, 1'b1);
      look();
      if (obs !== 3'b100) begin miscompares++; $display("FAIL rmm_hold: sfi=%b expected 100", obs); end
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      look();
      if (obs !== 3'b001) begin miscompares++; $display("FAIL rmm_issue_after_reset: sfi=%b expected 001", obs); end
      vectors++;
      if (bus.stall_cycles !== 32'd0) begin miscompares++; $display("FAIL rmm_stall_cycles: got %0d expected 0", bus.stall_cycles); end
      tick();
   endtask

   initial begin
      idle();
      test_reset();
      test_load_use();
      test_mul();
      test_sb_full();
      test_same_cycle();
      test_xcpt_flush();
      test_branch();
      test_cache_stall();
      test_reset_mid_mul();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
